// File: rtl/lm32_mul_tracker.sv
// Control tracker for the 3-stage pipelined multiplier: follows each multiply
// through M, P and R, strobes the register-file writeback and raises RAW interlocks.
module lm32_mul_tracker #(
    parameter int WORD_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_x,
    input  logic                  stall_m,
    input  logic                  kill_x,
    input  logic                  kill_m,
    input  logic                  valid_x,
    input  logic                  mul_x,
    input  logic [IDX_WIDTH-1:0]  dest_x,
    input  logic                  read_enable_0_d,
    input  logic [IDX_WIDTH-1:0]  read_idx_0_d,
    input  logic                  read_enable_1_d,
    input  logic [IDX_WIDTH-1:0]  read_idx_1_d,
    input  logic [WORD_WIDTH-1:0] mul_result,
    output logic                  wb_valid,
    output logic [IDX_WIDTH-1:0]  wb_idx,
    output logic [WORD_WIDTH-1:0] wb_data,
    output logic                  interlock,
    output logic                  busy
);

    logic                 m_vld_q, m_vld_d;
    logic [IDX_WIDTH-1:0] m_idx_q, m_idx_d;
    logic                 p_vld_q, p_vld_d;
    logic                 p_new_q, p_new_d;
    logic [IDX_WIDTH-1:0] p_idx_q, p_idx_d;
    logic                 r_vld_q, r_vld_d;
    logic [IDX_WIDTH-1:0] r_idx_q, r_idx_d;
    logic                 x_live;

    assign x_live = valid_x & mul_x & ~kill_x;

    always_comb begin
        m_vld_d = m_vld_q;
        m_idx_d = m_idx_q;
        p_vld_d = p_vld_q;
        p_idx_d = p_idx_q;
        p_new_d = 1'b0;
        // A stalled M stage holds everything, including the illegal stall_m-without-stall_x case.
        if (!stall_m) begin
            if (stall_x) begin
                m_vld_d = 1'b0;
            end else begin
                m_vld_d = x_live;
                m_idx_d = dest_x;
            end
            p_vld_d = m_vld_q & ~kill_m;
            p_idx_d = m_idx_q;
            p_new_d = m_vld_q & ~kill_m;
        end
        // p_new marks the first cycle a product appears, so a held product is written once.
        r_vld_d = p_new_q;
        r_idx_d = p_idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_vld_q <= 1'b0;
            m_idx_q <= '0;
            p_vld_q <= 1'b0;
            p_new_q <= 1'b0;
            p_idx_q <= '0;
            r_vld_q <= 1'b0;
            r_idx_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_idx_q <= m_idx_d;
            p_vld_q <= p_vld_d;
            p_new_q <= p_new_d;
            p_idx_q <= p_idx_d;
            r_vld_q <= r_vld_d;
            r_idx_q <= r_idx_d;
        end
    end

    function automatic logic pending_hit(
        input logic                 en,
        input logic [IDX_WIDTH-1:0] idx,
        input logic                 xl,
        input logic [IDX_WIDTH-1:0] dx,
        input logic                 mv,
        input logic [IDX_WIDTH-1:0] mi,
        input logic                 pv,
        input logic [IDX_WIDTH-1:0] pi,
        input logic                 rv,
        input logic [IDX_WIDTH-1:0] ri
    );
        return en && (idx != '0) &&
               ((xl && idx == dx) || (mv && idx == mi) ||
                (pv && idx == pi) || (rv && idx == ri));
    endfunction

    always_comb begin
        interlock = pending_hit(read_enable_0_d, read_idx_0_d, x_live, dest_x,
                                m_vld_q, m_idx_q, p_vld_q, p_idx_q, r_vld_q, r_idx_q)
                  | pending_hit(read_enable_1_d, read_idx_1_d, x_live, dest_x,
                                m_vld_q, m_idx_q, p_vld_q, p_idx_q, r_vld_q, r_idx_q);
    end

    assign wb_valid = r_vld_q & (r_idx_q != '0);
    assign wb_idx   = r_idx_q;
    assign wb_data  = mul_result;
    assign busy     = m_vld_q | p_vld_q | r_vld_q;

endmodule

// File: tb/tb_lm32_mul_tracker.sv
// Directed bench for lm32_mul_tracker: latency, stalls, kills, hazards and reset.
module tb_lm32_mul_tracker;

    localparam int WW = 32;
    localparam int IW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stall_x, stall_m, kill_x, kill_m, valid_x, mul_x;
    logic [IW-1:0] dest_x;
    logic          read_enable_0_d, read_enable_1_d;
    logic [IW-1:0] read_idx_0_d, read_idx_1_d;
    logic [WW-1:0] mul_result;
    logic          wb_valid, interlock, busy;
    logic [IW-1:0] wb_idx;
    logic [WW-1:0] wb_data;

    int tests = 0;
    int fails = 0;
    int illegal_cnt = 0;

    lm32_mul_tracker #(.WORD_WIDTH(WW), .IDX_WIDTH(IW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .stall_x(stall_x), .stall_m(stall_m), .kill_x(kill_x), .kill_m(kill_m),
        .valid_x(valid_x), .mul_x(mul_x), .dest_x(dest_x),
        .read_enable_0_d(read_enable_0_d), .read_idx_0_d(read_idx_0_d),
        .read_enable_1_d(read_enable_1_d), .read_idx_1_d(read_idx_1_d),
        .mul_result(mul_result),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .interlock(interlock), .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    // stall_m without stall_x is an illegal stimulus combination
    always @(posedge clk_i) begin
        if (!rst_i && stall_m && !stall_x) illegal_cnt <= illegal_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_i = 1'b0; stall_x = 1'b0; stall_m = 1'b0; kill_x = 1'b0; kill_m = 1'b0;
        valid_x = 1'b0; mul_x = 1'b0; dest_x = '0;
        read_enable_0_d = 1'b0; read_idx_0_d = '0;
        read_enable_1_d = 1'b0; read_idx_1_d = '0;
        mul_result = '0;
    endtask

    task automatic issue(input logic [IW-1:0] d);
        valid_x = 1'b1; mul_x = 1'b1; dest_x = d;
    endtask

    task automatic retire_x();
        valid_x = 1'b0; mul_x = 1'b0; dest_x = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        tests++;
        if ({wb_valid, wb_idx, interlock, busy} !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: got wb_valid=%b wb_idx=%0d interlock=%b busy=%b, want all 0",
                     wb_valid, wb_idx, interlock, busy);
        end
    endtask

    task automatic test_single();
        idle();
        issue(5'd5);
        tick();
        retire_x();
        for (int c = 1; c <= 5; c++) begin
            mul_result = (c == 3) ? 32'd42 : 32'd0;
            #1;
            tests++;
            if (wb_valid !== (c == 3) || busy !== (c <= 3)) begin
                fails++;
                $display("FAIL single c=%0d: got wb_valid=%b busy=%b, want %b %b",
                         c, wb_valid, busy, (c == 3), (c <= 3));
            end
            if (c == 3) begin
                tests++;
                if (wb_idx !== 5'd5 || wb_data !== 32'd42) begin
                    fails++;
                    $display("FAIL single_data: got idx=%0d data=%0d, want 5 42", wb_idx, wb_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall_m();
        idle();
        issue(5'd6);
        tick();
        retire_x();
        for (int c = 1; c <= 7; c++) begin
            stall_x = (c == 1 || c == 2);
            stall_m = (c == 1 || c == 2);
            mul_result = (c == 5) ? 32'd99 : 32'd0;
            #1;
            tests++;
            if (wb_valid !== (c == 5) || busy !== (c <= 5)) begin
                fails++;
                $display("FAIL stall_m c=%0d: got wb_valid=%b busy=%b, want %b %b",
                         c, wb_valid, busy, (c == 5), (c <= 5));
            end
            if (c == 5) begin
                tests++;
                if (wb_idx !== 5'd6 || wb_data !== 32'd99) begin
                    fails++;
                    $display("FAIL stall_data: got idx=%0d data=%0d, want 6 99", wb_idx, wb_data);
                end
            end
            tick();
        end
        idle();
    endtask

    // product held in P by a stall must still be written only once
    task automatic test_stall_p();
        idle();
        issue(5'd8);
        tick();
        retire_x();
        for (int c = 1; c <= 6; c++) begin
            stall_x = (c == 2 || c == 3);
            stall_m = (c == 2 || c == 3);
            #1;
            tests++;
            if (wb_valid !== (c == 3) || busy !== (c <= 4)) begin
                fails++;
                $display("FAIL stall_p c=%0d: got wb_valid=%b busy=%b, want %b %b",
                         c, wb_valid, busy, (c == 3), (c <= 4));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_kill();
        idle();
        issue(5'd3);
        kill_x = 1'b1;
        tick();
        retire_x();
        kill_x = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tests++;
            if (wb_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL kill_x c=%0d: got wb_valid=%b busy=%b, want 0 0", c, wb_valid, busy);
            end
            tick();
        end
        issue(5'd3);
        tick();
        retire_x();
        kill_m = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL kill_m_inflight: got busy=%b, want 1", busy);
        end
        tick();
        kill_m = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tests++;
            if (wb_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL kill_m c=%0d: got wb_valid=%b busy=%b, want 0 0", c, wb_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_interlock();
        idle();
        read_enable_1_d = 1'b1;
        read_idx_1_d = 5'd4;
        issue(5'd4);
        for (int c = 0; c <= 5; c++) begin
            #1;
            tests++;
            if (interlock !== (c <= 3)) begin
                fails++;
                $display("FAIL interlock_r4 c=%0d: got %b, want %b", c, interlock, (c <= 3));
            end
            tick();
            retire_x();
        end
        // reads of r9 and r0 around a mul to r0: no hazard, no strobe
        idle();
        read_enable_0_d = 1'b1; read_idx_0_d = 5'd9;
        read_enable_1_d = 1'b1; read_idx_1_d = 5'd0;
        issue(5'd0);
        for (int c = 0; c <= 4; c++) begin
            #1;
            tests++;
            if (interlock !== 1'b0 || wb_valid !== 1'b0 || busy !== (c >= 1 && c <= 3)) begin
                fails++;
                $display("FAIL r0_r9 c=%0d: got interlock=%b wb_valid=%b busy=%b, want 0 0 %b",
                         c, interlock, wb_valid, busy, (c >= 1 && c <= 3));
            end
            tick();
            retire_x();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        issue(5'd2);
        tick();
        issue(5'd7);
        tick();
        retire_x();
        for (int c = 2; c <= 6; c++) begin
            mul_result = (c == 3) ? 32'd14 : (c == 4) ? 32'd49 : 32'd0;
            #1;
            tests++;
            if (wb_valid !== (c == 3 || c == 4)) begin
                fails++;
                $display("FAIL b2b_valid c=%0d: got %b, want %b", c, wb_valid, (c == 3 || c == 4));
            end
            if (c == 3 || c == 4) begin
                tests++;
                if (wb_idx !== ((c == 3) ? 5'd2 : 5'd7) || wb_data !== ((c == 3) ? 32'd14 : 32'd49)) begin
                    fails++;
                    $display("FAIL b2b_data c=%0d: got idx=%0d data=%0d, want %0d %0d",
                             c, wb_idx, wb_data, (c == 3) ? 2 : 7, (c == 3) ? 14 : 49);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        read_enable_0_d = 1'b1;
        read_idx_0_d = 5'd5;
        issue(5'd5);
        tick();
        retire_x();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int c = 0; c <= 2; c++) begin
            tests++;
            if (wb_valid !== 1'b0 || interlock !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid c=%0d: got wb_valid=%b interlock=%b busy=%b, want 0 0 0",
                         c, wb_valid, interlock, busy);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_stall_m();
        test_stall_p();
        test_kill();
        test_interlock();
        test_back_to_back();
        test_reset_mid();
        tests++;
        if (illegal_cnt !== 0) begin
            fails++;
            $display("FAIL illegal_stall_combo: got %0d occurrences, want 0", illegal_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
